memory_port_arbiter: RTL

//  Shares one single-port BRAM between the instruction (i_mem_*) and data (d_mem_*) request

---
 rtl/memory_port_arbiter_pkg.sv | 20 ++
 rtl/memory_port_arbiter_starvation_counter.sv | 49 ++++
 rtl/memory_port_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter_pkg
//   Shared definitions for the single-port BRAM arbiter:
//     - owner_e : which requester owns the response stage
//     - counter_width() : bit width needed to count 0..limit inclusive
// ---------------------------------------------------------------------------
package memory_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Bits needed to hold every value from 0 up to and including limit.
  function automatic int counter_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/memory_port_arbiter_starvation_counter.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter_starvation_counter
//   Counts consecutive cycles in which a pending fetch lost arbitration.
//   Saturates at STARVE_LIMIT; starve is high once the limit is reached.
// Ports
//   clock   in  system clock
//   reset   in  synchronous, active-low reset (clears the count)
//   inc     in  fetch pending but not granted this cycle
//   clr     in  fetch granted or not pending (has priority over inc)
//   starve  out count has reached STARVE_LIMIT
// ---------------------------------------------------------------------------
module memory_port_arbiter_starvation_counter
  import memory_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic starve
);

  localparam int CNT_W = counter_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg < LIMIT)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign starve = (cnt_reg >= LIMIT);

endmodule

// File: rtl/memory_port_arbiter.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter
//   Shares one single-port BRAM between the instruction-fetch port (i_mem_*)
//   and the data port (d_mem_*). At most one request is granted per cycle;
//   data wins unless a fetch has been starved for STARVE_LIMIT cycles. Read
//   data (or a write ack) is returned one cycle after the grant, on the port
//   that owned that grant, together with an echo of the granted address.
// Ports
//   clock, reset        system clock, synchronous active-low reset
//   i_mem_read          fetch request (held until i_mem_ready)
//   i_mem_address_in    fetch address
//   i_mem_ready         fetch granted this cycle
//   i_mem_valid         fetch response valid
//   i_mem_data_out      fetch response data
//   i_mem_address_out   granted fetch address echo
//   d_mem_read/write    data read / write request (held until d_mem_ready)
//   d_mem_byte_en       write byte enables
//   d_mem_address_in    data address
//   d_mem_data_in       write data
//   d_mem_ready         data granted this cycle
//   d_mem_valid         data read response or write ack
//   d_mem_data_out      read data, 0 for a write ack
//   d_mem_address_out   granted data address echo
//   bram_enable/write   BRAM port enable / write strobe
//   bram_byte_en        BRAM byte enables (all ones on reads)
//   bram_address        BRAM word address (low MEM_ADDRESS_BITS of request)
//   bram_data_in        BRAM write data
//   bram_data_out       BRAM read data, one cycle after a read enable
// ---------------------------------------------------------------------------
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 14,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  // instruction fetch port
  input  logic                        i_mem_read,
  input  logic [ADDRESS_BITS-1:0]     i_mem_address_in,
  output logic                        i_mem_ready,
  output logic                        i_mem_valid,
  output logic [DATA_WIDTH-1:0]       i_mem_data_out,
  output logic [ADDRESS_BITS-1:0]     i_mem_address_out,
  // data port
  input  logic                        d_mem_read,
  input  logic                        d_mem_write,
  input  logic [DATA_WIDTH/8-1:0]     d_mem_byte_en,
  input  logic [ADDRESS_BITS-1:0]     d_mem_address_in,
  input  logic [DATA_WIDTH-1:0]       d_mem_data_in,
  output logic                        d_mem_ready,
  output logic                        d_mem_valid,
  output logic [DATA_WIDTH-1:0]       d_mem_data_out,
  output logic [ADDRESS_BITS-1:0]     d_mem_address_out,
  // BRAM port
  output logic                        bram_enable,
  output logic                        bram_write,
  output logic [DATA_WIDTH/8-1:0]     bram_byte_en,
  output logic [MEM_ADDRESS_BITS-1:0] bram_address,
  output logic [DATA_WIDTH-1:0]       bram_data_in,
  input  logic [DATA_WIDTH-1:0]       bram_data_out
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic d_req;
  logic i_req;
  logic starve;
  logic grant_d;
  logic grant_i;

  owner_e                  resp_owner_reg;
  owner_e                  resp_owner_next;
  logic                    resp_is_write_reg;
  logic                    resp_is_write_next;
  logic [ADDRESS_BITS-1:0] resp_addr_reg;
  logic [ADDRESS_BITS-1:0] resp_addr_next;

  // -------------------------------------------------------------------------
  // Grant logic. Gating with reset keeps every grant-derived output at 0
  // while reset is held, and lets the first grant happen in the very cycle
  // reset is released.
  // -------------------------------------------------------------------------
  assign d_req   = d_mem_read | d_mem_write;
  assign i_req   = i_mem_read;
  assign grant_d = reset & d_req & ~(i_req & starve);
  assign grant_i = reset & i_req & ~grant_d;

  assign i_mem_ready = grant_i;
  assign d_mem_ready = grant_d;

  // inc and clr are complementary: a pending fetch either lost (inc) or it
  // was granted / there was nothing pending (clr).
  memory_port_arbiter_starvation_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starvation_counter (
    .clock  (clock),
    .reset  (reset),
    .inc    (i_req & ~grant_i),
    .clr    (grant_i | ~i_req),
    .starve (starve)
  );

  // -------------------------------------------------------------------------
  // BRAM request mux. A data access with both read and write high is a write.
  // -------------------------------------------------------------------------
  always_comb begin
    bram_enable  = 1'b0;
    bram_write   = 1'b0;
    bram_byte_en = '0;
    bram_address = '0;
    bram_data_in = '0;
    if (grant_d) begin
      bram_enable  = 1'b1;
      bram_write   = d_mem_write;
      bram_byte_en = d_mem_write ? d_mem_byte_en : {BE_W{1'b1}};
      bram_address = d_mem_address_in[MEM_ADDRESS_BITS-1:0];
      bram_data_in = d_mem_data_in;
    end else if (grant_i) begin
      bram_enable  = 1'b1;
      bram_byte_en = {BE_W{1'b1}};
      bram_address = i_mem_address_in[MEM_ADDRESS_BITS-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Response stage: remembers who owns the access in flight so the BRAM read
  // data arriving next cycle can be steered to the right port.
  // -------------------------------------------------------------------------
  always_comb begin
    resp_owner_next    = OWN_NONE;
    resp_is_write_next = 1'b0;
    resp_addr_next     = '0;
    if (grant_d) begin
      resp_owner_next    = OWN_DATA;
      resp_is_write_next = d_mem_write;
      resp_addr_next     = d_mem_address_in;
    end else if (grant_i) begin
      resp_owner_next    = OWN_INSTR;
      resp_addr_next     = i_mem_address_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      resp_owner_reg    <= OWN_NONE;
      resp_is_write_reg <= 1'b0;
      resp_addr_reg     <= '0;
    end else begin
      resp_owner_reg    <= resp_owner_next;
      resp_is_write_reg <= resp_is_write_next;
      resp_addr_reg     <= resp_addr_next;
    end
  end

  // Response outputs. Gating with reset drops a response that was in flight
  // when reset asserted.
  always_comb begin
    i_mem_valid       = 1'b0;
    i_mem_data_out    = '0;
    i_mem_address_out = '0;
    d_mem_valid       = 1'b0;
    d_mem_data_out    = '0;
    d_mem_address_out = '0;
    if (reset) begin
      case (resp_owner_reg)
        OWN_INSTR: begin
          i_mem_valid       = 1'b1;
          i_mem_data_out    = bram_data_out;
          i_mem_address_out = resp_addr_reg;
        end
        OWN_DATA: begin
          d_mem_valid       = 1'b1;
          d_mem_data_out    = resp_is_write_reg ? '0 : bram_data_out;
          d_mem_address_out = resp_addr_reg;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
